fetch_group_unit: RTL and testbench
===================================

# fetch_group_unit

Parametrised fetch/pre-decode front end: generates aligned fetch groups of `FETCH_W` 16-bit instructions, talks to the instruction cache over a request/response handshake and holds the returned group in a compacting decode register. It also presents per-lane decoded fields and intra-group ROB-owner dependencies to the instruction buffer. Sits between the branch unit (redirects), the icache, and the instruction buffer/register file. Generalises the fixed 4-wide front end with a width parameter, a real FSM, partial-accept compaction and in-flight-response squashing on redirect.

## Interface
- `FETCH_W`, 4: instructions per group (≥2).
- `PC_W`, 16: PC width; byte address, instructions 2 bytes.
- `ROB_W`, 4: ROB index width; owners wrap mod 2^ROB_W.
- `RESET_PC`, 0: first fetch address.
- `CNT_W`, $clog2(FETCH_W+1): lane-count width (derived).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: branch-unit redirect.
- `redirect_pc` in PC_W: redirect target.
- `ic_req_valid` out 1: fetch request.
- `ic_req_ready` in 1: icache accepts request.
- `ic_req_pc_flat` out FETCH_W*PC_W: lane i address at [PC_W*i +: PC_W].
- `ic_rsp_valid` in 1: response for oldest outstanding request.
- `ic_rsp_instr_flat` in 16*FETCH_W: lane i at [16*i +: 16].
- `rob_head_idx` in ROB_W: ROB slot allocated to lane 0.
- `dq_accept` in CNT_W: lanes consumed by the instruction buffer this cycle (oldest first).
- `dq_count` out CNT_W: valid lanes in the decode register.
- `dq_opcode_flat`, `dq_rt_flat`, `dq_ra_flat`, `dq_rb_flat` out 4*FETCH_W: [15:12], [11:8], [7:4], [3:0].
- `dq_imm_flat` out 8*FETCH_W: [7:0].
- `dq_a_dep`, `dq_b_dep` out FETCH_W: operand produced by an older lane of the group.
- `dq_a_owner_flat`, `dq_b_owner_flat` out ROB_W*FETCH_W: owning ROB index.
- `dq_uses_ra`, `dq_uses_rb`, `dq_is_ld_str`, `dq_is_fxu`, `dq_is_branch` out FETCH_W: class bits.

## Operation
- Lane i address = `pc + 2*i`, PC_W wrap-around.
- FSM states:
  - S_REQ: `ic_req_valid`=1; on `ic_req_ready` → S_WAIT.
  - S_WAIT: on `ic_rsp_valid`, load all lanes, count=FETCH_W, pc += 2*FETCH_W → S_HOLD.
  - S_HOLD: eff = min(dq_accept, count); shift lanes down by eff, count -= eff; count reaching 0 → S_REQ.
  - S_DROP: discard next `ic_rsp_valid` → S_REQ.
- Redirect, any state, highest priority: count=0, pc=redirect_pc; `dq_accept` ignored. Next state:
  - S_DROP if a request is outstanding (S_WAIT, or S_REQ with ready this cycle).
  - S_DROP in S_DROP without `ic_rsp_valid`.
  - S_REQ otherwise.
- Decode classes: uses_ra {0,1,2,3,4,8,9,10,11}; uses_rb {0,1,4,10,11}; ld_str {2,3}; fxu {0,1,4,5,6}; branch {8..11}; writes_rt {0,1,2,4,5,6}.
- Dependencies: for valid lane i and operand x∈{a,b}, find youngest j<i (j<count) with writes_rt_j and rt_j==rx_i and uses_rx_i.
  - Match: owner = rob_head_idx+j, dep=1.
  - No match: owner = rob_head_idx+i, dep=0. Lane 0 dep is always 0.
- Lanes ≥ count drive all fields 0.

## Timing
- Reset values: state S_REQ, pc=RESET_PC, count 0, all dq_* 0; `ic_req_valid` low while `rst_n` low, high first cycle after release.
- Request to decode output: 1 cycle after `ic_rsp_valid` edge.
- Decoded fields and owners are combinational from the decode register and `rob_head_idx`.
- Compaction visible the cycle after accept.
- Next request issues the cycle after count reaches 0. No fetch-ahead.
- Response in S_REQ/S_HOLD is a protocol error. Not required to be handled.
- Reset mid-operation: immediate return to reset values. Any in-flight response after reset release is not squashed (icache resets together).

## Structure
- Shared package `fetch_pkg`: opcode constants, class-set functions (`uses_ra`, `uses_rb`, `writes_rt`, `is_ld_str`, `is_fxu`, `is_branch`), FSM state enum.
- Sub-module `group_dep_check`: combinational per-lane owner search, parametrised on FETCH_W/ROB_W.

## Test plan
- Reset release, FETCH_W=4, ready=1, rsp 2 cycles later → first request PCs 0,2,4,6; `dq_count`=4; next request 8..14 only after 4 lanes accepted.
- Group [add r1,r2,r3; add r4,r1,r1; st r1; add r5,r4,r1], head=14:
  - lane1 a/b owner 14, dep=1.
  - lane3 a owner 15 (wrap check), b owner 14.
  - store rt never a producer.
- `dq_accept`=3 then 1 → count 4→1→0, old lane3 at lane0 with owners recomputed from current head.
- Redirect to 0x40 during S_WAIT; stale rsp arrives → dropped, count stays 0; next request 0x40..0x46.
- Redirect same cycle as `ic_rsp_valid` and as accepted request → response ignored / S_DROP respectively, no stale lanes appear.
- `rst_n` low mid-S_HOLD → all outputs 0 asynchronously, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - opcode constants, decode class sets and FSM state for the fetch front end
package fetch_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_LI  = 4'h5;
    localparam logic [3:0] OP_LUI = 4'h6;
    localparam logic [3:0] OP_JR  = 4'h8;
    localparam logic [3:0] OP_JAL = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    function automatic logic uses_ra(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LD, OP_ST, OP_AND,
            OP_JR, OP_JAL, OP_BEQ, OP_BNE: uses_ra = 1'b1;
            default:                       uses_ra = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rb(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_BEQ, OP_BNE: uses_rb = 1'b1;
            default:                               uses_rb = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rt(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LD, OP_AND, OP_LI, OP_LUI: writes_rt = 1'b1;
            default:                                     writes_rt = 1'b0;
        endcase
    endfunction

    function automatic logic is_ld_str(input logic [3:0] op);
        is_ld_str = (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_fxu(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_LI, OP_LUI: is_fxu = 1'b1;
            default:                              is_fxu = 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        case (op)
            OP_JR, OP_JAL, OP_BEQ, OP_BNE: is_branch = 1'b1;
            default:                       is_branch = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/group_dep_check.sv
// rtl/group_dep_check.sv - per-lane ROB owner search against older lanes of the same group
module group_dep_check #(
    parameter int FETCH_W = 4,
    parameter int ROB_W   = 4,
    parameter int CNT_W   = $clog2(FETCH_W + 1)
) (
    input  logic [16*FETCH_W-1:0]    instr_flat,
    input  logic [CNT_W-1:0]         count,
    input  logic [ROB_W-1:0]         rob_head_idx,
    output logic [FETCH_W-1:0]       a_dep,
    output logic [FETCH_W-1:0]       b_dep,
    output logic [ROB_W*FETCH_W-1:0] a_owner_flat,
    output logic [ROB_W*FETCH_W-1:0] b_owner_flat
);
    import fetch_pkg::*;

    // Ascending scan over older lanes so the youngest matching producer wins
    always_comb begin
        a_dep        = '0;
        b_dep        = '0;
        a_owner_flat = '0;
        b_owner_flat = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (CNT_W'(i) < count) begin
                a_owner_flat[ROB_W*i +: ROB_W] = rob_head_idx + ROB_W'(i);
                b_owner_flat[ROB_W*i +: ROB_W] = rob_head_idx + ROB_W'(i);
                for (int j = 0; j < i; j++) begin
                    if (writes_rt(instr_flat[16*j+12 +: 4])) begin
                        if (uses_ra(instr_flat[16*i+12 +: 4]) &&
                            (instr_flat[16*j+8 +: 4] == instr_flat[16*i+4 +: 4])) begin
                            a_owner_flat[ROB_W*i +: ROB_W] = rob_head_idx + ROB_W'(j);
                            a_dep[i] = 1'b1;
                        end
                        if (uses_rb(instr_flat[16*i+12 +: 4]) &&
                            (instr_flat[16*j+8 +: 4] == instr_flat[16*i +: 4])) begin
                            b_owner_flat[ROB_W*i +: ROB_W] = rob_head_idx + ROB_W'(j);
                            b_dep[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fetch_group_unit.sv
// rtl/fetch_group_unit.sv - fetch FSM, icache handshake, compacting decode register and pre-decode
module fetch_group_unit #(
    parameter int              FETCH_W  = 4,
    parameter int              PC_W     = 16,
    parameter int              ROB_W    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = $clog2(FETCH_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     ic_req_valid,
    input  logic                     ic_req_ready,
    output logic [FETCH_W*PC_W-1:0]  ic_req_pc_flat,
    input  logic                     ic_rsp_valid,
    input  logic [16*FETCH_W-1:0]    ic_rsp_instr_flat,
    input  logic [ROB_W-1:0]         rob_head_idx,
    input  logic [CNT_W-1:0]         dq_accept,
    output logic [CNT_W-1:0]         dq_count,
    output logic [4*FETCH_W-1:0]     dq_opcode_flat,
    output logic [4*FETCH_W-1:0]     dq_rt_flat,
    output logic [4*FETCH_W-1:0]     dq_ra_flat,
    output logic [4*FETCH_W-1:0]     dq_rb_flat,
    output logic [8*FETCH_W-1:0]     dq_imm_flat,
    output logic [FETCH_W-1:0]       dq_a_dep,
    output logic [FETCH_W-1:0]       dq_b_dep,
    output logic [ROB_W*FETCH_W-1:0] dq_a_owner_flat,
    output logic [ROB_W*FETCH_W-1:0] dq_b_owner_flat,
    output logic [FETCH_W-1:0]       dq_uses_ra,
    output logic [FETCH_W-1:0]       dq_uses_rb,
    output logic [FETCH_W-1:0]       dq_is_ld_str,
    output logic [FETCH_W-1:0]       dq_is_fxu,
    output logic [FETCH_W-1:0]       dq_is_branch
);
    import fetch_pkg::*;

    fetch_state_t               state, state_n;
    logic [PC_W-1:0]            pc, pc_n;
    logic [CNT_W-1:0]           count, count_n, eff;
    logic [FETCH_W-1:0][15:0]   lanes, lanes_n;

    // Request is held off during reset so the icache never sees a stale fetch
    assign ic_req_valid = rst_n && (state == S_REQ);
    assign eff          = (dq_accept < count) ? dq_accept : count;
    assign dq_count     = count;

    // Lane addresses step by one 16-bit instruction and wrap at PC_W
    always_comb begin
        ic_req_pc_flat = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            ic_req_pc_flat[PC_W*i +: PC_W] = pc + PC_W'(2*i);
        end
    end

    // Next-state, fetch PC and decode-register update; redirect overrides everything
    always_comb begin
        state_n = state;
        pc_n    = pc;
        count_n = count;
        lanes_n = lanes;
        case (state)
            S_REQ: begin
                if (ic_req_ready) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (ic_rsp_valid) begin
                    lanes_n = ic_rsp_instr_flat;
                    count_n = CNT_W'(FETCH_W);
                    pc_n    = pc + PC_W'(2*FETCH_W);
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                for (int k = 0; k < FETCH_W; k++) begin
                    lanes_n[k] = '0;
                    for (int s = 0; s < FETCH_W; s++) begin
                        if (s == k + int'(eff)) lanes_n[k] = lanes[s];
                    end
                end
                count_n = count - eff;
                if (count == eff) state_n = S_REQ;
            end
            S_DROP: begin
                if (ic_rsp_valid) state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase
        if (redirect_valid) begin
            count_n = '0;
            lanes_n = '0;
            pc_n    = redirect_pc;
            // A response still owed by the icache must be swallowed before refetching
            if (((state == S_WAIT) && !ic_rsp_valid) ||
                ((state == S_REQ)  && ic_req_ready)  ||
                ((state == S_DROP) && !ic_rsp_valid))
                state_n = S_DROP;
            else
                state_n = S_REQ;
        end
    end

    // State, PC and decode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            count <= '0;
            lanes <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            count <= count_n;
            lanes <= lanes_n;
        end
    end

    // Field extraction and class bits; lanes past count read as zero
    always_comb begin
        dq_opcode_flat = '0;
        dq_rt_flat     = '0;
        dq_ra_flat     = '0;
        dq_rb_flat     = '0;
        dq_imm_flat    = '0;
        dq_uses_ra     = '0;
        dq_uses_rb     = '0;
        dq_is_ld_str   = '0;
        dq_is_fxu      = '0;
        dq_is_branch   = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (CNT_W'(i) < count) begin
                dq_opcode_flat[4*i +: 4] = lanes[i][15:12];
                dq_rt_flat[4*i +: 4]     = lanes[i][11:8];
                dq_ra_flat[4*i +: 4]     = lanes[i][7:4];
                dq_rb_flat[4*i +: 4]     = lanes[i][3:0];
                dq_imm_flat[8*i +: 8]    = lanes[i][7:0];
                dq_uses_ra[i]            = uses_ra(lanes[i][15:12]);
                dq_uses_rb[i]            = uses_rb(lanes[i][15:12]);
                dq_is_ld_str[i]          = is_ld_str(lanes[i][15:12]);
                dq_is_fxu[i]             = is_fxu(lanes[i][15:12]);
                dq_is_branch[i]          = is_branch(lanes[i][15:12]);
            end
        end
    end

    group_dep_check #(
        .FETCH_W (FETCH_W),
        .ROB_W   (ROB_W),
        .CNT_W   (CNT_W)
    ) u_dep (
        .instr_flat   (lanes),
        .count        (count),
        .rob_head_idx (rob_head_idx),
        .a_dep        (dq_a_dep),
        .b_dep        (dq_b_dep),
        .a_owner_flat (dq_a_owner_flat),
        .b_owner_flat (dq_b_owner_flat)
    );

endmodule

// File: tb/tb_fetch_group_unit.sv
// tb/tb_fetch_group_unit.sv - scoreboard bench for fetch_group_unit against a queue-based reference model
module tb_fetch_group_unit;

    localparam int F  = 4;
    localparam int PW = 16;
    localparam int RW = 4;
    localparam int CW = $clog2(F + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            redirect_valid;
    logic [PW-1:0]   redirect_pc;
    logic            ic_req_valid;
    logic            ic_req_ready;
    logic [F*PW-1:0] ic_req_pc_flat;
    logic            ic_rsp_valid;
    logic [16*F-1:0] ic_rsp_instr_flat;
    logic [RW-1:0]   rob_head_idx;
    logic [CW-1:0]   dq_accept;
    logic [CW-1:0]   dq_count;
    logic [4*F-1:0]  dq_opcode_flat, dq_rt_flat, dq_ra_flat, dq_rb_flat;
    logic [8*F-1:0]  dq_imm_flat;
    logic [F-1:0]    dq_a_dep, dq_b_dep;
    logic [RW*F-1:0] dq_a_owner_flat, dq_b_owner_flat;
    logic [F-1:0]    dq_uses_ra, dq_uses_rb, dq_is_ld_str, dq_is_fxu, dq_is_branch;

    fetch_group_unit #(.FETCH_W(F), .PC_W(PW), .ROB_W(RW), .RESET_PC(16'h0000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .ic_req_valid      (ic_req_valid),
        .ic_req_ready      (ic_req_ready),
        .ic_req_pc_flat    (ic_req_pc_flat),
        .ic_rsp_valid      (ic_rsp_valid),
        .ic_rsp_instr_flat (ic_rsp_instr_flat),
        .rob_head_idx      (rob_head_idx),
        .dq_accept         (dq_accept),
        .dq_count          (dq_count),
        .dq_opcode_flat    (dq_opcode_flat),
        .dq_rt_flat        (dq_rt_flat),
        .dq_ra_flat        (dq_ra_flat),
        .dq_rb_flat        (dq_rb_flat),
        .dq_imm_flat       (dq_imm_flat),
        .dq_a_dep          (dq_a_dep),
        .dq_b_dep          (dq_b_dep),
        .dq_a_owner_flat   (dq_a_owner_flat),
        .dq_b_owner_flat   (dq_b_owner_flat),
        .dq_uses_ra        (dq_uses_ra),
        .dq_uses_rb        (dq_uses_rb),
        .dq_is_ld_str      (dq_is_ld_str),
        .dq_is_fxu         (dq_is_fxu),
        .dq_is_branch      (dq_is_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rv;
        logic [PW-1:0]      pc;
        int                 cnt;
        logic [F-1:0][15:0] ins;
        logic [RW-1:0]      head;
    } exp_t;

    exp_t          sb[$];
    logic [15:0]   m_q[$];
    logic [PW-1:0] m_pc;
    bit            m_outst;
    bit            m_stale;
    int            n_pass  = 0;
    int            n_total = 0;

    function automatic bit r_uses_ra(int op);  return op inside {0,1,2,3,4,8,9,10,11}; endfunction
    function automatic bit r_uses_rb(int op);  return op inside {0,1,4,10,11};         endfunction
    function automatic bit r_ld_str(int op);   return op inside {2,3};                 endfunction
    function automatic bit r_fxu(int op);      return op inside {0,1,4,5,6};           endfunction
    function automatic bit r_branch(int op);   return op inside {8,9,10,11};           endfunction
    function automatic bit r_writes(int op);   return op inside {0,1,2,4,5,6};         endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_q.delete();
        m_pc    = 16'h0000;
        m_outst = 1'b0;
        m_stale = 1'b0;
    endtask

    // Drives one cycle of inputs, records the outputs expected this cycle, then advances the model
    task automatic step(input logic redir, input logic [PW-1:0] rpc, input logic rdy, input logic rsp,
                        input logic [16*F-1:0] ins, input logic [RW-1:0] head, input logic [CW-1:0] acc);
        exp_t e;
        int   n;
        logic [15:0] d;
        redirect_valid    = redir;
        redirect_pc       = rpc;
        ic_req_ready      = rdy;
        ic_rsp_valid      = rsp;
        ic_rsp_instr_flat = ins;
        rob_head_idx      = head;
        dq_accept         = acc;
        e.rv   = rst_n && !m_outst && (m_q.size() == 0);
        e.pc   = m_pc;
        e.cnt  = m_q.size();
        e.head = head;
        for (int i = 0; i < F; i++) e.ins[i] = (i < m_q.size()) ? m_q[i] : 16'h0;
        sb.push_back(e);
        if (rst_n) begin
            if (redir) begin
                bit keep;
                keep = (m_outst && !rsp) || (e.rv && rdy);
                m_q.delete();
                m_pc    = rpc;
                m_outst = keep;
                m_stale = keep;
            end else if (e.rv && rdy) begin
                m_outst = 1'b1;
                m_stale = 1'b0;
            end else if (m_outst && rsp) begin
                if (!m_stale) begin
                    for (int i = 0; i < F; i++) m_q.push_back(ins[16*i +: 16]);
                    m_pc = m_pc + PW'(2*F);
                end
                m_outst = 1'b0;
                m_stale = 1'b0;
            end else begin
                n = (int'(acc) < m_q.size()) ? int'(acc) : m_q.size();
                for (int i = 0; i < n; i++) d = m_q.pop_front();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every sampled cycle is compared against the oldest recorded expectation
    always @(negedge clk) begin : monitor
        exp_t            e;
        logic [F*PW-1:0] x_pc;
        logic [4*F-1:0]  x_op, x_rt, x_ra, x_rb;
        logic [8*F-1:0]  x_imm;
        logic [F-1:0]    x_ad, x_bd, x_ura, x_urb, x_ls, x_fx, x_br;
        logic [RW*F-1:0] x_ao, x_bo;
        int              op;
        bit              found;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            x_pc = '0; x_op = '0; x_rt = '0; x_ra = '0; x_rb = '0; x_imm = '0;
            x_ad = '0; x_bd = '0; x_ura = '0; x_urb = '0; x_ls = '0; x_fx = '0; x_br = '0;
            x_ao = '0; x_bo = '0;
            for (int i = 0; i < F; i++) x_pc[PW*i +: PW] = e.pc + PW'(2*i);
            for (int i = 0; i < e.cnt; i++) begin
                op = int'(e.ins[i][15:12]);
                x_op[4*i +: 4]  = e.ins[i][15:12];
                x_rt[4*i +: 4]  = e.ins[i][11:8];
                x_ra[4*i +: 4]  = e.ins[i][7:4];
                x_rb[4*i +: 4]  = e.ins[i][3:0];
                x_imm[8*i +: 8] = e.ins[i][7:0];
                x_ura[i] = r_uses_ra(op);
                x_urb[i] = r_uses_rb(op);
                x_ls[i]  = r_ld_str(op);
                x_fx[i]  = r_fxu(op);
                x_br[i]  = r_branch(op);
                x_ao[RW*i +: RW] = e.head + RW'(i);
                x_bo[RW*i +: RW] = e.head + RW'(i);
                found = 0;
                for (int j = i - 1; j >= 0; j--) begin
                    if (!found && r_uses_ra(op) && r_writes(int'(e.ins[j][15:12])) &&
                        e.ins[j][11:8] == e.ins[i][7:4]) begin
                        found = 1; x_ad[i] = 1'b1; x_ao[RW*i +: RW] = e.head + RW'(j);
                    end
                end
                found = 0;
                for (int j = i - 1; j >= 0; j--) begin
                    if (!found && r_uses_rb(op) && r_writes(int'(e.ins[j][15:12])) &&
                        e.ins[j][11:8] == e.ins[i][3:0]) begin
                        found = 1; x_bd[i] = 1'b1; x_bo[RW*i +: RW] = e.head + RW'(j);
                    end
                end
            end
            chk("req_valid", ic_req_valid, e.rv);
            if (e.rv) chk("req_pc", ic_req_pc_flat, x_pc);
            chk("count", dq_count, e.cnt);
            chk("opcode", dq_opcode_flat, x_op);
            chk("rt", dq_rt_flat, x_rt);
            chk("ra", dq_ra_flat, x_ra);
            chk("rb", dq_rb_flat, x_rb);
            chk("imm", dq_imm_flat, x_imm);
            chk("a_dep", dq_a_dep, x_ad);
            chk("b_dep", dq_b_dep, x_bd);
            chk("a_owner", dq_a_owner_flat, x_ao);
            chk("b_owner", dq_b_owner_flat, x_bo);
            chk("uses_ra", dq_uses_ra, x_ura);
            chk("uses_rb", dq_uses_rb, x_urb);
            chk("ld_str", dq_is_ld_str, x_ls);
            chk("fxu", dq_is_fxu, x_fx);
            chk("branch", dq_is_branch, x_br);
        end
    end

    // add r1,r2,r3 ; add r4,r1,r1 ; st r1 ; add r5,r4,r1  (lane 0 in the low bits)
    localparam logic [63:0] GRP = {16'h0541, 16'h3100, 16'h0411, 16'h0123};

    initial begin : driver
        logic [16*F-1:0] ins;
        logic [PW-1:0]   rpc;
        rst_n = 1'b0;
        redirect_valid = 0; redirect_pc = 0; ic_req_ready = 0; ic_rsp_valid = 0;
        ic_rsp_instr_flat = 0; rob_head_idx = 0; dq_accept = 0;
        m_reset();
        @(posedge clk); #1;
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_req_valid", ic_req_valid, 1'b0);
        chk("reset_count", dq_count, 0);
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", ic_req_valid, 1'b1);
        chk("first_req_pcs", ic_req_pc_flat, 64'h0006_0004_0002_0000);
        step(0, 0, 1, 0, 0, 14, 0);
        step(0, 0, 0, 0, 0, 14, 0);
        step(0, 0, 0, 1, GRP, 14, 0);
        chk("load_count", dq_count, 4);
        chk("l1_a_owner", dq_a_owner_flat[RW*1 +: RW], 14);
        chk("l1_b_owner", dq_b_owner_flat[RW*1 +: RW], 14);
        chk("l1_a_dep", dq_a_dep[1], 1'b1);
        chk("l3_a_owner_wrap", dq_a_owner_flat[RW*3 +: RW], 15);
        chk("l3_b_owner_skip_store", dq_b_owner_flat[RW*3 +: RW], 14);
        chk("l3_b_dep", dq_b_dep[3], 1'b1);
        chk("l2_ld_str", dq_is_ld_str[2], 1'b1);
        step(0, 0, 1, 0, 0, 14, 0);
        chk("hold_no_req", ic_req_valid, 1'b0);
        step(0, 0, 0, 0, 0, 2, 3);
        chk("compact_count", dq_count, 1);
        chk("compact_rt", dq_rt_flat[3:0], 5);
        chk("compact_owner", dq_a_owner_flat[RW-1:0], 2);
        chk("compact_dep", dq_a_dep[0], 1'b0);
        step(0, 0, 0, 0, 0, 2, 1);
        chk("drain_count", dq_count, 0);
        chk("next_req_valid", ic_req_valid, 1'b1);
        chk("next_req_pcs", ic_req_pc_flat, 64'h000E_000C_000A_0008);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 16'h0040, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, GRP, 0, 0);
        chk("stale_dropped_count", dq_count, 0);
        chk("redir_req_pcs", ic_req_pc_flat, 64'h0046_0044_0042_0040);
        step(1, 16'h0080, 1, 0, 0, 0, 0);
        chk("drop_no_req", ic_req_valid, 1'b0);
        step(0, 0, 0, 1, GRP, 0, 0);
        chk("drop_count", dq_count, 0);
        chk("drop_req_pc", ic_req_pc_flat[PW-1:0], 16'h0080);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 16'h0100, 0, 1, GRP, 0, 0);
        chk("redir_rsp_count", dq_count, 0);
        chk("redir_rsp_req", ic_req_valid, 1'b1);
        chk("redir_rsp_pc", ic_req_pc_flat[PW-1:0], 16'h0100);
        step(0, 0, 1, 0, 0, 3, 0);
        step(0, 0, 0, 1, GRP, 3, 0);
        chk("pre_reset_count", dq_count, 4);
        rst_n = 1'b0;
        #1;
        chk("async_count", dq_count, 0);
        chk("async_req_valid", ic_req_valid, 1'b0);
        chk("async_opcode", dq_opcode_flat, 0);
        chk("async_owner", dq_a_owner_flat, 0);
        m_reset();
        step(0, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 3, 0);
        rst_n = 1'b1;
        #1;
        chk("restart_req_valid", ic_req_valid, 1'b1);
        chk("restart_pc", ic_req_pc_flat[PW-1:0], 16'h0000);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < F; i++) begin
                ins[16*i +: 16] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            end
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC : PW'($urandom & 32'hFFFE);
            step(($urandom_range(0, 19) == 0), rpc, ($urandom_range(0, 2) != 0),
                 m_outst && ($urandom_range(0, 2) == 0), ins,
                 RW'($urandom_range(0, 15)), CW'($urandom_range(0, F)));
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
